// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a synchronized lock,
// requires the lock to stay stable, then releases the downstream ADC reset.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 100,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       adc_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                                      CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, lock_s_q;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, adc_rst_q, ready_q, fail_q;
  logic             timeout;
  logic             enter;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    enter   = 1'b0;
    timeout = (state_q == S_WAIT_LOCK) && !lock_s_q && (cnt_q == TO_LAST);

    case (state_q)
      S_PLL_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          enter   = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (timeout) begin
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
          state_d = (32'(retry_d) > MAX_RETRIES) ? S_FAIL : S_PLL_RESET;
          enter   = 1'b1;
        end else if (lock_s_q) begin
          state_d = S_STABILIZE;
          enter   = 1'b1;
        end
      end
      S_STABILIZE: begin
        // A dropout restarts the wait window but is not a timeout.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          enter   = 1'b1;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          enter   = 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          state_d = S_PLL_RESET;
          enter   = 1'b1;
        end
      end
      S_FAIL:  ;
      default: begin
        state_d = S_PLL_RESET;
        enter   = 1'b1;
      end
    endcase

    // A relock request loses only to a timeout, which already restarts the PLL.
    if (force_relock && (state_q != S_FAIL) && !timeout) begin
      state_d = S_PLL_RESET;
      enter   = 1'b1;
    end

    if (enter)                 cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: all state uses non-blocking assignments; reset is synchronous, so
  // rst is just another input sampled on the refclk edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RESET;
      cnt_q     <= '0;
      sync_q    <= 1'b0;
      lock_s_q  <= 1'b0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      adc_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync_q    <= pll_locked;
      lock_s_q  <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == S_PLL_RESET) || (state_d == S_FAIL);
      adc_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign pll_rst   = pll_rst_q;
  // Lock loss in RUN must hold the ADC domain in reset without waiting a cycle.
  assign adc_rst   = adc_rst_q | ((state_q == S_RUN) && !lock_s_q);
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, corner-case sequences
// and random lock/relock traffic, all compared every cycle to a reference model.
module tb_pll_lock_supervisor;

  localparam int RST_P = 4;
  localparam int TO_P  = 20;
  localparam int STB_P = 8;
  localparam int MAX_R = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, adc_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (RST_P),
    .LOCK_TIMEOUT_CYCLES(TO_P),
    .LOCK_STABLE_CYCLES (STB_P),
    .MAX_RETRIES        (MAX_R)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .adc_rst     (adc_rst),
    .ready       (ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase described by counters of elapsed cycles.
  // m_pulse > 0 : PLL reset pulse cycles left; m_wait >= 0 : cycles spent
  // waiting for lock; m_stab >= 0 : locked cycles seen while stabilizing.
  int m_pulse, m_wait, m_stab, m_retry, m_loss;
  bit m_run, m_fail, m_s1, m_s2;

  task automatic model_edge(input bit r, input bit lk_in, input bit frc);
    bit lk;
    bit to;
    lk = m_s2;
    to = 1'b0;
    if (r) begin
      m_pulse = RST_P; m_wait = -1; m_stab = -1; m_run = 0; m_fail = 0;
      m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      if (m_fail) begin
      end else if (m_pulse > 0) begin
        m_pulse--;
        if (m_pulse == 0) m_wait = 0;
      end else if (m_wait >= 0) begin
        if (!lk && (m_wait + 1 == TO_P)) begin
          to = 1'b1;
          m_wait = -1;
          m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          if (m_retry > MAX_R) m_fail = 1;
          else m_pulse = RST_P;
        end else if (lk) begin
          m_wait = -1; m_stab = 0;
        end else begin
          m_wait++;
        end
      end else if (m_stab >= 0) begin
        if (!lk) begin
          m_stab = -1; m_wait = 0;
        end else if (m_stab + 1 == STB_P) begin
          m_stab = -1; m_run = 1;
        end else begin
          m_stab++;
        end
      end else if (m_run) begin
        if (!lk) begin
          m_run = 0; m_pulse = RST_P;
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        end
      end
      if (frc && !m_fail && !to) begin
        m_pulse = RST_P; m_wait = -1; m_stab = -1; m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = lk_in;
    end
  endtask

  task automatic cmp_model();
    check("model_pll_rst",   pll_rst,   (m_fail || m_pulse > 0));
    check("model_adc_rst",   adc_rst,   (!m_run || !m_s2));
    check("model_ready",     ready,     m_run);
    check("model_fail",      fail,      m_fail);
    check("model_retry_cnt", retry_cnt, m_retry);
    check("model_loss_cnt",  loss_cnt,  m_loss);
  endtask

  task automatic step(input bit r, input bit lk, input bit frc);
    rst = r; pll_locked = lk; force_relock = frc;
    @(posedge refclk);
    model_edge(r, lk, frc);
    #1;
    cmp_model();
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 60 && ready !== 1'b1; k++) step(0, 1, 0);
    check("wait_ready", ready, 1);
  endtask

  task automatic drop_lock();
    for (int k = 0; k < 10 && pll_rst !== 1'b1; k++) step(0, 0, 0);
    check("drop_pll_rst", pll_rst, 1);
  endtask

  typedef struct {
    bit r; bit lk; bit frc; int n;
    bit e_pll; bit e_adc; bit e_rdy; bit e_fail; int e_retry; int e_loss;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl[NVEC];

  initial begin
    int prev;
    int hi;
    bit lk;

    //           r  lk frc n    pll adc rdy fail retry loss
    tbl[0]  = '{1, 0, 0, 2,   1,  1,  0,  0,   0,    0};  // reset state
    tbl[1]  = '{0, 0, 0, 3,   1,  1,  0,  0,   0,    0};  // pulse still high
    tbl[2]  = '{0, 0, 0, 1,   0,  1,  0,  0,   0,    0};  // 4th cycle: release
    tbl[3]  = '{0, 0, 0, 4,   0,  1,  0,  0,   0,    0};
    tbl[4]  = '{0, 1, 0, 1,   0,  1,  0,  0,   0,    0};  // lock rises
    tbl[5]  = '{0, 1, 0, 9,   0,  1,  0,  0,   0,    0};  // 10 edges: not ready
    tbl[6]  = '{0, 1, 0, 1,   0,  0,  1,  0,   0,    0};  // 11th edge: ready
    tbl[7]  = '{0, 0, 0, 1,   0,  0,  1,  0,   0,    0};  // lock drops
    tbl[8]  = '{0, 0, 0, 1,   0,  1,  1,  0,   0,    0};  // adc_rst immediate
    tbl[9]  = '{0, 0, 0, 1,   1,  1,  0,  0,   0,    1};  // new pulse, loss 1
    tbl[10] = '{0, 0, 0, 3,   1,  1,  0,  0,   0,    1};
    tbl[11] = '{0, 0, 0, 1,   0,  1,  0,  0,   0,    1};
    tbl[12] = '{0, 1, 0, 5,   0,  1,  0,  0,   0,    1};  // glitch high 5
    tbl[13] = '{0, 0, 0, 2,   0,  1,  0,  0,   0,    1};
    tbl[14] = '{0, 0, 0, 1,   0,  1,  0,  0,   0,    1};  // back to wait
    tbl[15] = '{0, 0, 0, 19,  0,  1,  0,  0,   0,    1};  // one short of timeout
    tbl[16] = '{0, 0, 0, 1,   1,  1,  0,  0,   1,    1};  // timeout
    tbl[17] = '{0, 0, 1, 1,   1,  1,  0,  0,   1,    1};  // force restarts pulse
    tbl[18] = '{0, 0, 0, 3,   1,  1,  0,  0,   1,    1};
    tbl[19] = '{0, 0, 0, 1,   0,  1,  0,  0,   1,    1};

    for (int i = 0; i < NVEC; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].lk, tbl[i].frc);
      check($sformatf("vec%0d_pll_rst", i), pll_rst,   tbl[i].e_pll);
      check($sformatf("vec%0d_adc_rst", i), adc_rst,   tbl[i].e_adc);
      check($sformatf("vec%0d_ready", i),   ready,     tbl[i].e_rdy);
      check($sformatf("vec%0d_fail", i),    fail,      tbl[i].e_fail);
      check($sformatf("vec%0d_retry", i),   retry_cnt, tbl[i].e_retry);
      check($sformatf("vec%0d_loss", i),    loss_cnt,  tbl[i].e_loss);
    end

    // force_relock coincident with timeout: the timeout still counts
    for (int k = 0; k < TO_P - 1; k++) step(0, 0, 0);
    step(0, 0, 1);
    check("force_timeout_retry", retry_cnt, 2);
    check("force_timeout_pll_rst", pll_rst, 1);

    // force_relock coincident with lock loss in RUN: the loss still counts
    wait_ready();
    step(0, 0, 0);
    step(0, 0, 0);
    check("loss_pending_adc_rst", adc_rst, 1);
    step(0, 0, 1);
    check("force_loss_cnt", loss_cnt, 2);
    check("force_loss_ready", ready, 0);

    // Timeouts until FAIL
    step(1, 0, 0);
    prev = 0;
    for (int k = 0; k < 300 && fail !== 1'b1; k++) begin
      step(0, 0, 0);
      if (retry_cnt !== 4'(prev)) begin
        check("retry_increment", retry_cnt, prev + 1);
        prev = int'(retry_cnt);
      end
    end
    check("fail_retry_cnt", retry_cnt, 3);
    check("fail_flag", fail, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 1);
    check("fail_ignores_force", fail, 1);
    check("fail_pll_rst", pll_rst, 1);
    check("fail_adc_rst", adc_rst, 1);

    // Reset out of FAIL
    step(1, 0, 0);
    check("rst_fail_clear", fail, 0);
    check("rst_retry_clear", retry_cnt, 0);
    check("rst_loss_clear", loss_cnt, 0);
    hi = 0;
    while (pll_rst === 1'b1 && hi < 20) begin
      step(0, 0, 0);
      hi++;
    end
    check("rst_pulse_width", hi, RST_P);

    // Loss counter saturation
    for (int i = 0; i < 256; i++) begin
      wait_ready();
      drop_lock();
      if (i == 254) check("loss_cnt_255", loss_cnt, 255);
    end
    check("loss_cnt_saturated", loss_cnt, 255);

    // Random traffic
    step(1, 0, 0);
    lk = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) lk = !lk;
      step(($urandom_range(399) == 0), lk, ($urandom_range(199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
